// File: rtl/alu_exec_pipe_if.sv
// Issue, register-file read, writeback and branch-resolution signals of alu_exec_pipe.
// The slave modport is the execution unit; the master modport is its environment.
interface alu_exec_pipe_if #(
    parameter int INST_ID_BIT    = 8,
    parameter int NUM_REG        = 8,
    parameter int IMM_BIT        = 4,
    parameter int DATA_BIT       = 16,
    parameter int SPEC_DEPTH     = 4,
    parameter int REG_ID_BIT     = $clog2(NUM_REG),
    parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1
);
    logic                                       in_vld;
    logic                                       in_rdy;
    logic [INST_ID_BIT-1:0]                     in_id;
    logic [REG_ID_BIT-1:0]                      in_dst_reg;
    logic [REG_ID_BIT-1:0]                      in_src_reg0;
    logic [REG_ID_BIT-1:0]                      in_src_reg1;
    logic [IMM_BIT-1:0]                         in_imm;
    logic [SPEC_LEVEL_BIT-1:0]                  in_spec_level;
    logic [REG_ID_BIT-1:0]                      rf_rd_addr0;
    logic [REG_ID_BIT-1:0]                      rf_rd_addr1;
    logic [DATA_BIT-1:0]                        rf_rd_data0;
    logic [DATA_BIT-1:0]                        rf_rd_data1;
    logic                                       wb_vld;
    logic                                       wb_rdy;
    logic [INST_ID_BIT-1:0]                     wb_id;
    logic [REG_ID_BIT-1:0]                      wb_dst_reg;
    logic [DATA_BIT-1:0]                        wb_data;
    logic [SPEC_LEVEL_BIT-1:0]                  wb_spec_level;
    logic [NUM_REG-1:0]                         pending_write;
    logic                                       empty;
    logic                                       br_pred_vld;
    logic                                       br_pred_rdy;
    logic                                       br_pred_succ;
    logic [SPEC_LEVEL_BIT-1:0]                  br_pred_fail_level;
    logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0]   br_pred_succ_nxt_levels;

    modport slave (
        input  in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1, in_imm, in_spec_level,
        input  rf_rd_data0, rf_rd_data1, wb_rdy,
        input  br_pred_vld, br_pred_succ, br_pred_fail_level, br_pred_succ_nxt_levels,
        output in_rdy, rf_rd_addr0, rf_rd_addr1,
        output wb_vld, wb_id, wb_dst_reg, wb_data, wb_spec_level,
        output pending_write, empty, br_pred_rdy
    );

    modport master (
        output in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1, in_imm, in_spec_level,
        output rf_rd_data0, rf_rd_data1, wb_rdy,
        output br_pred_vld, br_pred_succ, br_pred_fail_level, br_pred_succ_nxt_levels,
        input  in_rdy, rf_rd_addr0, rf_rd_addr1,
        input  wb_vld, wb_id, wb_dst_reg, wb_data, wb_spec_level,
        input  pending_write, empty, br_pred_rdy
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// Integer execution unit: src0 + src1 + imm through a LATENCY-deep elastic pipeline,
// with branch-speculation squash (fail) and level remap (success) on in-flight entries.
module alu_exec_pipe #(
    parameter int INST_ID_BIT    = 8,
    parameter int NUM_REG        = 8,
    parameter int IMM_BIT        = 4,
    parameter int DATA_BIT       = 16,
    parameter int SPEC_DEPTH     = 4,
    parameter int LATENCY        = 2,
    parameter int REG_ID_BIT     = $clog2(NUM_REG),
    parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_pipe_if.slave bus
);
    localparam int LAST    = LATENCY - 1;
    localparam int TBL_BIT = SPEC_LEVEL_BIT * (SPEC_DEPTH + 1);

    logic [LATENCY-1:0]                     vld_q, vld_d;
    logic [LATENCY-1:0][INST_ID_BIT-1:0]    id_q, id_d;
    logic [LATENCY-1:0][REG_ID_BIT-1:0]     dst_q, dst_d;
    logic [LATENCY-1:0][DATA_BIT-1:0]       data_q, data_d;
    logic [LATENCY-1:0][SPEC_LEVEL_BIT-1:0] lvl_q, lvl_d;

    logic [LATENCY-1:0]                     squash_s;
    logic [LATENCY-1:0]                     free_s;
    logic [LATENCY-1:0][SPEC_LEVEL_BIT-1:0] lvl_nxt_s;
    logic                                   fail_s;
    logic                                   succ_s;
    logic                                   in_kill_s;
    logic [DATA_BIT-1:0]                    sum_s;
    logic [NUM_REG-1:0]                     pending_s;

    // Levels outside the remap table are left untouched.
    function automatic logic [SPEC_LEVEL_BIT-1:0] remap_level(
        input logic [SPEC_LEVEL_BIT-1:0] lvl,
        input logic [TBL_BIT-1:0]        tbl
    );
        logic [SPEC_LEVEL_BIT-1:0] r;
        r = lvl;
        for (int i = 0; i <= SPEC_DEPTH; i++) begin
            r = (lvl == SPEC_LEVEL_BIT'(i)) ? tbl[i*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] : r;
        end
        return r;
    endfunction

    assign fail_s    = bus.br_pred_vld & ~bus.br_pred_succ;
    assign succ_s    = bus.br_pred_vld &  bus.br_pred_succ;
    assign in_kill_s = fail_s & (bus.in_spec_level >= bus.br_pred_fail_level);
    assign sum_s     = bus.rf_rd_data0 + bus.rf_rd_data1
                     + {{(DATA_BIT-IMM_BIT){1'b0}}, bus.in_imm};

    // Per-stage squash, remapped level, and vacate chain (a stage is free if empty or moving on).
    always_comb begin
        squash_s  = '0;
        free_s    = '0;
        lvl_nxt_s = '0;
        for (int k = 0; k < LATENCY; k++) begin
            squash_s[k]  = fail_s & vld_q[k] & (lvl_q[k] >= bus.br_pred_fail_level);
            lvl_nxt_s[k] = succ_s ? remap_level(lvl_q[k], bus.br_pred_succ_nxt_levels) : lvl_q[k];
        end
        free_s[LAST] = ~vld_q[LAST] | bus.wb_rdy | squash_s[LAST];
        for (int k = LAST - 1; k >= 0; k--) begin
            free_s[k] = ~vld_q[k] | free_s[k+1];
        end
    end

    // Next-state per stage: load from upstream when free, otherwise hold; squash clears vld either way.
    always_comb begin
        vld_d  = vld_q;
        id_d   = id_q;
        dst_d  = dst_q;
        data_d = data_q;
        lvl_d  = lvl_q;
        if (free_s[0]) begin
            vld_d[0]  = bus.in_vld & ~in_kill_s;
            id_d[0]   = bus.in_id;
            dst_d[0]  = bus.in_dst_reg;
            data_d[0] = sum_s;
            lvl_d[0]  = bus.in_spec_level;
        end else begin
            vld_d[0]  = vld_q[0] & ~squash_s[0];
            lvl_d[0]  = lvl_nxt_s[0];
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (free_s[k]) begin
                vld_d[k]  = vld_q[k-1] & ~squash_s[k-1];
                id_d[k]   = id_q[k-1];
                dst_d[k]  = dst_q[k-1];
                data_d[k] = data_q[k-1];
                lvl_d[k]  = lvl_nxt_s[k-1];
            end else begin
                vld_d[k]  = vld_q[k] & ~squash_s[k];
                lvl_d[k]  = lvl_nxt_s[k];
            end
        end
    end

    // Stage valid bits: the only reset state of the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stage payloads are qualified by vld_q and need no reset.
    always_ff @(posedge clk) begin
        id_q   <= id_d;
        dst_q  <= dst_d;
        data_q <= data_d;
        lvl_q  <= lvl_d;
    end

    // One-hot destination OR of all registered-valid stages.
    always_comb begin
        pending_s = '0;
        for (int k = 0; k < LATENCY; k++) begin
            pending_s = pending_s
                      | (vld_q[k] ? ({{(NUM_REG-1){1'b0}}, 1'b1} << dst_q[k]) : '0);
        end
    end

    assign bus.in_rdy        = free_s[0];
    assign bus.rf_rd_addr0   = bus.in_src_reg0;
    assign bus.rf_rd_addr1   = bus.in_src_reg1;
    assign bus.wb_vld        = vld_q[LAST] & ~squash_s[LAST];
    assign bus.wb_id         = id_q[LAST];
    assign bus.wb_dst_reg    = dst_q[LAST];
    assign bus.wb_data       = data_q[LAST];
    assign bus.wb_spec_level = lvl_nxt_s[LAST];
    assign bus.pending_write = pending_s;
    assign bus.empty         = ~|vld_q;
    assign bus.br_pred_rdy   = 1'b1;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed, table-driven bench for alu_exec_pipe (LATENCY = 2) plus hand-written
// sequences for backpressure, rollback, success remap and mid-operation reset.
module tb_alu_exec_pipe;
    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    alu_exec_pipe_if bus ();
    alu_exec_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [3:0]  imm;
        logic [7:0]  id;
        logic [2:0]  dst;
        logic [2:0]  lvl;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    logic [14:0] tbl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_vld      = 1'b0;
        bus.br_pred_vld = 1'b0;
        bus.br_pred_succ = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        bus.in_vld        = 1'b1;
        bus.in_id         = v.id;
        bus.in_dst_reg    = v.dst;
        bus.in_src_reg0   = v.dst ^ 3'd1;
        bus.in_src_reg1   = v.dst ^ 3'd2;
        bus.in_imm        = v.imm;
        bus.in_spec_level = v.lvl;
        bus.rf_rd_data0   = v.d0;
        bus.rf_rd_data1   = v.d1;
    endtask

    function automatic vec_t mk(input logic [15:0] d0, input logic [15:0] d1, input logic [3:0] imm,
                                input logic [7:0] id, input logic [2:0] dst, input logic [2:0] lvl,
                                input logic [15:0] exp);
        vec_t v;
        v.d0 = d0; v.d1 = d1; v.imm = imm; v.id = id; v.dst = dst; v.lvl = lvl; v.exp = exp;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(16'h0003, 16'h0004, 4'h5, 8'h11, 3'd2, 3'd0, 16'h000C);
        vecs[1] = mk(16'hFFFF, 16'h0001, 4'h1, 8'h22, 3'd5, 3'd1, 16'h0001);
        vecs[2] = mk(16'h0000, 16'h0000, 4'h0, 8'h33, 3'd0, 3'd2, 16'h0000);
        vecs[3] = mk(16'h1234, 16'h4321, 4'hF, 8'h44, 3'd7, 3'd3, 16'h5564);
        vecs[4] = mk(16'h8000, 16'h8000, 4'h0, 8'h55, 3'd1, 3'd4, 16'h0000);
        vecs[5] = mk(16'h00FF, 16'hFF01, 4'h3, 8'h66, 3'd4, 3'd0, 16'h0003);
        // remap table: 0->0, 1->0, 2->1, 3->2, 4->3
        tbl = {3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

        rst_n = 1'b0;
        idle();
        bus.wb_rdy = 1'b1;
        bus.in_id = 8'h00; bus.in_dst_reg = 3'd0; bus.in_src_reg0 = 3'd0; bus.in_src_reg1 = 3'd0;
        bus.in_imm = 4'h0; bus.in_spec_level = 3'd0;
        bus.rf_rd_data0 = 16'h0000; bus.rf_rd_data1 = 16'h0000;
        bus.br_pred_fail_level = 3'd0;
        bus.br_pred_succ_nxt_levels = tbl;

        // reset state
        smp();
        check("reset_wb_vld", 32'(bus.wb_vld), 32'd0);
        check("reset_empty", 32'(bus.empty), 32'd1);
        check("reset_pending", 32'(bus.pending_write), 32'd0);
        check("reset_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("br_pred_rdy", 32'(bus.br_pred_rdy), 32'd1);
        rst_n = 1'b1;
        tick();

        // single-issue vectors: latency, fields, pending_write
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            smp();
            check("vec_in_rdy", 32'(bus.in_rdy), 32'd1);
            check("vec_rf_addr0", 32'(bus.rf_rd_addr0), 32'(vecs[i].dst ^ 3'd1));
            tick();
            idle();
            smp();
            check("vec_wb_vld_early", 32'(bus.wb_vld), 32'd0);
            check("vec_pending", 32'(bus.pending_write), 32'(8'd1 << vecs[i].dst));
            tick();
            smp();
            check("vec_wb_vld", 32'(bus.wb_vld), 32'd1);
            check("vec_wb_data", 32'(bus.wb_data), 32'(vecs[i].exp));
            check("vec_wb_id", 32'(bus.wb_id), 32'(vecs[i].id));
            check("vec_wb_dst", 32'(bus.wb_dst_reg), 32'(vecs[i].dst));
            check("vec_wb_lvl", 32'(bus.wb_spec_level), 32'(vecs[i].lvl));
            tick();
            smp();
            check("vec_empty_after", 32'(bus.empty), 32'd1);
            tick();
        end

        // back-to-back throughput
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) drive(vecs[c]);
            else idle();
            smp();
            if (c < NV) check("thr_in_rdy", 32'(bus.in_rdy), 32'd1);
            if (c >= 2) begin
                check("thr_wb_vld", 32'(bus.wb_vld), 32'd1);
                check("thr_wb_data", 32'(bus.wb_data), 32'(vecs[c-2].exp));
                check("thr_wb_id", 32'(bus.wb_id), 32'(vecs[c-2].id));
            end
            tick();
        end
        smp();
        check("thr_empty", 32'(bus.empty), 32'd1);
        tick();

        // backpressure: 2 accepts then in_rdy low; release drains in order
        bus.wb_rdy = 1'b0;
        drive(vecs[0]);
        smp();
        check("bp_rdy0", 32'(bus.in_rdy), 32'd1);
        tick();
        drive(vecs[1]);
        smp();
        check("bp_rdy1", 32'(bus.in_rdy), 32'd1);
        tick();
        drive(vecs[3]);
        smp();
        check("bp_rdy2_low", 32'(bus.in_rdy), 32'd0);
        check("bp_hold_vld", 32'(bus.wb_vld), 32'd1);
        check("bp_hold_data", 32'(bus.wb_data), 32'(vecs[0].exp));
        tick();
        smp();
        check("bp_rdy_still_low", 32'(bus.in_rdy), 32'd0);
        check("bp_hold_id", 32'(bus.wb_id), 32'(vecs[0].id));
        check("bp_pending", 32'(bus.pending_write), 32'h24);
        bus.wb_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bus.in_rdy), 32'd1);
        tick();
        idle();
        smp();
        check("bp_out1_vld", 32'(bus.wb_vld), 32'd1);
        check("bp_out1_id", 32'(bus.wb_id), 32'(vecs[1].id));
        tick();
        smp();
        check("bp_out2_vld", 32'(bus.wb_vld), 32'd1);
        check("bp_out2_data", 32'(bus.wb_data), 32'(vecs[3].exp));
        tick();
        smp();
        check("bp_drained", 32'(bus.empty), 32'd1);
        tick();

        // rollback: level-1 survives, level-2 squashed, incoming level-3 accepted but dropped
        drive(mk(16'h0001, 16'h0002, 4'h3, 8'h51, 3'd1, 3'd1, 16'h0006));
        tick();
        drive(mk(16'h0010, 16'h0020, 4'h0, 8'h52, 3'd3, 3'd2, 16'h0030));
        tick();
        drive(mk(16'h0100, 16'h0200, 4'h0, 8'h53, 3'd4, 3'd3, 16'h0300));
        bus.br_pred_vld = 1'b1;
        bus.br_pred_succ = 1'b0;
        bus.br_pred_fail_level = 3'd2;
        smp();
        check("rb_wb_vld", 32'(bus.wb_vld), 32'd1);
        check("rb_wb_id", 32'(bus.wb_id), 32'h51);
        check("rb_wb_data", 32'(bus.wb_data), 32'h0006);
        check("rb_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rb_pending_unmasked", 32'(bus.pending_write), 32'h0A);
        tick();
        idle();
        smp();
        check("rb_no_wb", 32'(bus.wb_vld), 32'd0);
        check("rb_empty", 32'(bus.empty), 32'd1);
        check("rb_pending", 32'(bus.pending_write), 32'd0);
        tick();
        smp();
        check("rb_no_wb_later", 32'(bus.wb_vld), 32'd0);
        tick();

        // rollback on the stalled last stage: wb_vld drops same cycle, empty does not
        bus.wb_rdy = 1'b0;
        drive(mk(16'h0001, 16'h0001, 4'h0, 8'h5A, 3'd6, 3'd3, 16'h0002));
        tick();
        idle();
        tick();
        bus.br_pred_vld = 1'b1;
        bus.br_pred_fail_level = 3'd1;
        smp();
        check("rbl_wb_vld", 32'(bus.wb_vld), 32'd0);
        check("rbl_empty_reg", 32'(bus.empty), 32'd0);
        check("rbl_pending_reg", 32'(bus.pending_write), 32'h40);
        tick();
        idle();
        smp();
        check("rbl_empty_after", 32'(bus.empty), 32'd1);
        bus.wb_rdy = 1'b1;
        tick();

        // success while in flight: level 2 remapped to 1
        drive(mk(16'h0005, 16'h0005, 4'h0, 8'h61, 3'd0, 3'd2, 16'h000A));
        tick();
        idle();
        bus.br_pred_vld = 1'b1;
        bus.br_pred_succ = 1'b1;
        smp();
        check("sc_wb_vld_early", 32'(bus.wb_vld), 32'd0);
        tick();
        idle();
        smp();
        check("sc_wb_vld", 32'(bus.wb_vld), 32'd1);
        check("sc_wb_id", 32'(bus.wb_id), 32'h61);
        check("sc_wb_lvl", 32'(bus.wb_spec_level), 32'd1);
        tick();

        // success in the wb_vld cycle itself: level 3 shows as 2, and stays 2
        drive(mk(16'h0007, 16'h0000, 4'h0, 8'h62, 3'd3, 3'd3, 16'h0007));
        tick();
        idle();
        tick();
        bus.wb_rdy = 1'b0;
        smp();
        check("sw_lvl_stored", 32'(bus.wb_spec_level), 32'd3);
        bus.br_pred_vld = 1'b1;
        bus.br_pred_succ = 1'b1;
        #1;
        check("sw_lvl_remapped", 32'(bus.wb_spec_level), 32'd2);
        tick();
        idle();
        smp();
        check("sw_vld_held", 32'(bus.wb_vld), 32'd1);
        check("sw_lvl_kept", 32'(bus.wb_spec_level), 32'd2);
        bus.wb_rdy = 1'b1;
        tick();
        smp();
        check("sw_empty", 32'(bus.empty), 32'd1);
        tick();

        // reset with 2 entries in flight
        bus.wb_rdy = 1'b0;
        drive(vecs[0]);
        tick();
        drive(vecs[1]);
        tick();
        idle();
        smp();
        check("rst_pre_vld", 32'(bus.wb_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wb_vld", 32'(bus.wb_vld), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_pending", 32'(bus.pending_write), 32'd0);
        tick();
        smp();
        rst_n = 1'b1;
        bus.wb_rdy = 1'b1;
        tick();
        drive(vecs[3]);
        tick();
        idle();
        tick();
        smp();
        check("rst_after_vld", 32'(bus.wb_vld), 32'd1);
        check("rst_after_data", 32'(bus.wb_data), 32'(vecs[3].exp));
        check("rst_after_id", 32'(bus.wb_id), 32'(vecs[3].id));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
